// File: rtl/npc_unit.sv
// Next-PC generator for the single-cycle MIPS datapath.
// Produces PC+4 and the selected next PC combinationally, plus a
// one-cycle registered copy of the next PC and a redirect flag.
module npc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] nPC_pc,
   input  logic [15:0] nPC_offset,
   input  logic [25:0] nPC_addr_j,
   input  logic [31:0] nPC_addr_reg,
   input  logic [1:0]  nPC_control,
   output logic [31:0] nPC_npc,
   output logic [31:0] nPC_pc_plus_4,
   output logic [31:0] nPC_npc_q,
   output logic        nPC_redirect_q
);

   typedef enum logic [1:0] {
      IFU_NORMAL = 2'b00,
      IFU_BRANCH = 2'b01,
      IFU_JUMP   = 2'b10,
      IFU_JREG   = 2'b11
   } ifuSel_e;

   ifuSel_e     selCtl;
   logic [31:0] pcPlus4;
   logic [31:0] branchOffset;
   logic [31:0] branchTarget;
   logic [31:0] jumpTarget;
   logic [31:0] npcNext;

   assign selCtl = ifuSel_e'(nPC_control);

   // Link value and sequential target; wraps silently at 2^32
   always_comb begin
      pcPlus4 = nPC_pc + 32'd4;
   end

   // Candidate targets: sign-extended word offset, and the region-relative
   // jump whose upper nibble comes from PC+4 (delay-slot region), not PC
   always_comb begin
      branchOffset = {{14{nPC_offset[15]}}, nPC_offset, 2'b00};
      branchTarget = pcPlus4 + branchOffset;
      jumpTarget   = {pcPlus4[31:28], nPC_addr_j, 2'b00};
   end

   // Next-PC select; all four encodings are meaningful
   always_comb begin
      npcNext = pcPlus4;
      case (selCtl)
         IFU_NORMAL: npcNext = pcPlus4;
         IFU_BRANCH: npcNext = branchTarget;
         IFU_JUMP:   npcNext = jumpTarget;
         IFU_JREG:   npcNext = nPC_addr_reg;
      endcase
   end

   assign nPC_npc       = npcNext;
   assign nPC_pc_plus_4 = pcPlus4;

   // Registered next PC and redirect flag, sampled every cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         nPC_npc_q      <= RESET_PC;
         nPC_redirect_q <= 1'b0;
      end else begin
         nPC_npc_q      <= npcNext;
         nPC_redirect_q <= (selCtl != IFU_NORMAL);
      end
   end

endmodule

// File: tb/tb_npc_unit.sv
// Self-checking bench for npc_unit: combinational selection, registered
// path, reset behaviour and randomised back-to-back traffic.
module tb_npc_unit;

   localparam logic [1:0] C_NORMAL = 2'b00;
   localparam logic [1:0] C_BRANCH = 2'b01;
   localparam logic [1:0] C_JUMP   = 2'b10;
   localparam logic [1:0] C_JREG   = 2'b11;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc = '0;
   logic [15:0] offset = '0;
   logic [25:0] addrJ = '0;
   logic [31:0] addrReg = '0;
   logic [1:0]  control = C_NORMAL;
   logic [31:0] npc, pcPlus4, npcQ;
   logic        redirQ;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
   } expEntry_t;

   expEntry_t sb[$];
   expEntry_t e;
   int nCompared = 0;
   int nMismatched = 0;

   npc_unit #(.RESET_PC(32'h0000_3000)) dut (
      .clk(clk), .reset(reset), .nPC_pc(pc), .nPC_offset(offset),
      .nPC_addr_j(addrJ), .nPC_addr_reg(addrReg), .nPC_control(control),
      .nPC_npc(npc), .nPC_pc_plus_4(pcPlus4), .nPC_npc_q(npcQ),
      .nPC_redirect_q(redirQ)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] refNpc(input logic [31:0] p, input logic [15:0] o,
                                          input logic [25:0] j, input logic [31:0] r,
                                          input logic [1:0] c);
      logic signed [31:0] so;
      logic [31:0] seq;
      seq = p + 32'd4;
      so  = 32'(signed'(o));
      case (c)
         C_BRANCH: return seq + 32'(so * 4);
         C_JUMP:   return (seq & 32'hF000_0000) | (32'(j) << 2);
         C_JREG:   return r;
         default:  return seq;
      endcase
   endfunction

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1; control = C_BRANCH; pc = 32'h0000_5000; offset = 16'h0010;
      sb.push_back('{"reset_q", 32'h0000_3000, 32'd0});
      @(posedge clk); #1;
      e = sb.pop_front();
      nCompared++;
      if (npcQ !== e.a || {31'd0, redirQ} !== e.b) begin
         nMismatched++;
         $display("FAIL %s: npc_q=%h redir=%b, expected npc_q=%h redir=%0d", e.name, npcQ, redirQ, e.a, e.b);
      end
      // combinational outputs must track inputs while reset is held
      sb.push_back('{"reset_comb", 32'h0000_5044, 32'h0000_5004});
      e = sb.pop_front();
      nCompared++;
      if (npc !== e.a || pcPlus4 !== e.b) begin
         nMismatched++;
         $display("FAIL %s: npc=%h p4=%h, expected npc=%h p4=%h", e.name, npc, pcPlus4, e.a, e.b);
      end
   endtask

   task automatic test_normal();
      logic [31:0] pcs [3] = '{32'h0000_0010, 32'h0000_3004, 32'hFFFF_FFFC};
      logic [31:0] exps[3] = '{32'h0000_0014, 32'h0000_3008, 32'h0000_0000};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         control = C_NORMAL; pc = pcs[i]; offset = 16'hABCD; addrJ = 26'h3FF_FFFF; addrReg = 32'hDEAD_BEEF;
         sb.push_back('{$sformatf("normal_%0d", i), exps[i], exps[i]});
         #1;
         e = sb.pop_front();
         nCompared++;
         if (npc !== e.a || pcPlus4 !== e.b) begin
            nMismatched++;
            $display("FAIL %s: npc=%h p4=%h, expected npc=%h p4=%h", e.name, npc, pcPlus4, e.a, e.b);
         end
      end
   endtask

   task automatic test_branch();
      logic [31:0] pcs [3] = '{32'h0000_3004, 32'h0000_3008, 32'h0000_3008};
      logic [15:0] offs[3] = '{16'hFFFF, 16'hFFF0, 16'h0002};
      logic [31:0] exps[3] = '{32'h0000_3004, 32'h0000_2FCC, 32'h0000_3014};
      logic [31:0] p4s [3] = '{32'h0000_3008, 32'h0000_300C, 32'h0000_300C};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         control = C_BRANCH; pc = pcs[i]; offset = offs[i];
         sb.push_back('{$sformatf("branch_%0d", i), exps[i], p4s[i]});
         #1;
         e = sb.pop_front();
         nCompared++;
         if (npc !== e.a || pcPlus4 !== e.b) begin
            nMismatched++;
            $display("FAIL %s: npc=%h p4=%h, expected npc=%h p4=%h", e.name, npc, pcPlus4, e.a, e.b);
         end
      end
   endtask

   task automatic test_jump();
      @(negedge clk);
      control = C_JUMP; pc = 32'hFFFF_FF00; addrJ = 26'h000_3000; offset = 16'h8000;
      sb.push_back('{"jump", 32'hF000_C000, 32'hFFFF_FF04});
      #1;
      e = sb.pop_front();
      nCompared++;
      if (npc !== e.a || pcPlus4 !== e.b) begin
         nMismatched++;
         $display("FAIL %s: npc=%h p4=%h, expected npc=%h p4=%h", e.name, npc, pcPlus4, e.a, e.b);
      end
      // upper nibble must follow PC+4 when PC+4 crosses a 256MB region
      @(negedge clk);
      pc = 32'h0FFF_FFFC; addrJ = 26'h000_0001;
      sb.push_back('{"jump_region", 32'h1000_0004, 32'h1000_0000});
      #1;
      e = sb.pop_front();
      nCompared++;
      if (npc !== e.a || pcPlus4 !== e.b) begin
         nMismatched++;
         $display("FAIL %s: npc=%h p4=%h, expected npc=%h p4=%h", e.name, npc, pcPlus4, e.a, e.b);
      end
   endtask

   task automatic test_jreg();
      @(negedge clk);
      control = C_JREG; pc = 32'hFFFF_FF00; addrReg = 32'h1234_5678;
      for (int i = 0; i < 3; i++) begin
         offset = 16'(i * 16'h1357); addrJ = 26'(i * 26'h0AB_CDEF);
         sb.push_back('{$sformatf("jreg_%0d", i), 32'h1234_5678, 32'hFFFF_FF04});
         #1;
         e = sb.pop_front();
         nCompared++;
         if (npc !== e.a || pcPlus4 !== e.b) begin
            nMismatched++;
            $display("FAIL %s: npc=%h p4=%h, expected npc=%h p4=%h", e.name, npc, pcPlus4, e.a, e.b);
         end
      end
   endtask

   task automatic test_registered();
      @(negedge clk);
      reset = 1'b1; control = C_NORMAL; pc = 32'h0000_3000;
      sb.push_back('{"reg_reset", 32'h0000_3000, 32'd0});
      @(negedge clk);
      reset = 1'b0;
      sb.push_back('{"reg_normal", 32'h0000_3004, 32'd0});
      @(negedge clk);
      control = C_JREG; addrReg = 32'h0000_3010;
      sb.push_back('{"reg_jreg", 32'h0000_3010, 32'd1});
      @(negedge clk);
      // three expectations pushed, checked after each of the edges just passed
      // is not possible retroactively, so re-run with per-edge checks below
      sb.delete();
      reset = 1'b1; control = C_NORMAL; pc = 32'h0000_3000;
      sb.push_back('{"reg_reset", 32'h0000_3000, 32'd0});
      @(posedge clk); #1;
      e = sb.pop_front();
      nCompared++;
      if (npcQ !== e.a || {31'd0, redirQ} !== e.b) begin
         nMismatched++;
         $display("FAIL %s: npc_q=%h redir=%b, expected npc_q=%h redir=%0d", e.name, npcQ, redirQ, e.a, e.b);
      end
      @(negedge clk);
      reset = 1'b0;
      sb.push_back('{"reg_normal", 32'h0000_3004, 32'd0});
      @(posedge clk); #1;
      e = sb.pop_front();
      nCompared++;
      if (npcQ !== e.a || {31'd0, redirQ} !== e.b) begin
         nMismatched++;
         $display("FAIL %s: npc_q=%h redir=%b, expected npc_q=%h redir=%0d", e.name, npcQ, redirQ, e.a, e.b);
      end
      @(negedge clk);
      control = C_JREG; addrReg = 32'h0000_3010;
      sb.push_back('{"reg_jreg", 32'h0000_3010, 32'd1});
      @(posedge clk); #1;
      e = sb.pop_front();
      nCompared++;
      if (npcQ !== e.a || {31'd0, redirQ} !== e.b) begin
         nMismatched++;
         $display("FAIL %s: npc_q=%h redir=%b, expected npc_q=%h redir=%0d", e.name, npcQ, redirQ, e.a, e.b);
      end
   endtask

   task automatic test_reset_midstream();
      @(negedge clk);
      reset = 1'b0; control = C_BRANCH; pc = 32'h0000_3008; offset = 16'h0002;
      sb.push_back('{"mid_branch_q", 32'h0000_3014, 32'd1});
      @(posedge clk); #1;
      e = sb.pop_front();
      nCompared++;
      if (npcQ !== e.a || {31'd0, redirQ} !== e.b) begin
         nMismatched++;
         $display("FAIL %s: npc_q=%h redir=%b, expected npc_q=%h redir=%0d", e.name, npcQ, redirQ, e.a, e.b);
      end
      @(negedge clk);
      reset = 1'b1;
      sb.push_back('{"mid_reset_q", 32'h0000_3000, 32'd0});
      @(posedge clk); #1;
      e = sb.pop_front();
      nCompared++;
      if (npcQ !== e.a || {31'd0, redirQ} !== e.b) begin
         nMismatched++;
         $display("FAIL %s: npc_q=%h redir=%b, expected npc_q=%h redir=%0d", e.name, npcQ, redirQ, e.a, e.b);
      end
      nCompared++;
      if (npc !== 32'h0000_3014) begin
         nMismatched++;
         $display("FAIL mid_reset_comb: npc=%h, expected npc=%h", npc, 32'h0000_3014);
      end
      @(negedge clk);
      reset = 1'b0;
      sb.push_back('{"mid_release_q", 32'h0000_3014, 32'd1});
      @(posedge clk); #1;
      e = sb.pop_front();
      nCompared++;
      if (npcQ !== e.a || {31'd0, redirQ} !== e.b) begin
         nMismatched++;
         $display("FAIL %s: npc_q=%h redir=%b, expected npc_q=%h redir=%0d", e.name, npcQ, redirQ, e.a, e.b);
      end
   endtask

   task automatic test_back_to_back();
      // stimulus changes every cycle; expectations queue up one cycle ahead
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 200; i++) begin
         pc = $urandom(); offset = 16'($urandom()); addrJ = 26'($urandom());
         addrReg = $urandom(); control = 2'($urandom_range(0, 3));
         sb.push_back('{$sformatf("b2b_%0d", i), refNpc(pc, offset, addrJ, addrReg, control),
                        {31'd0, control != C_NORMAL}});
         #1;
         nCompared++;
         if (npc !== refNpc(pc, offset, addrJ, addrReg, control) || pcPlus4 !== pc + 32'd4) begin
            nMismatched++;
            $display("FAIL b2b_comb_%0d: npc=%h p4=%h, expected npc=%h p4=%h", i, npc, pcPlus4,
                     refNpc(pc, offset, addrJ, addrReg, control), pc + 32'd4);
         end
         @(posedge clk); #1;
         if (sb.size() == 0) begin
            nCompared++; nMismatched++;
            $display("FAIL b2b_queue: scoreboard empty at cycle %0d, expected one entry", i);
         end else begin
            e = sb.pop_front();
            nCompared++;
            if (npcQ !== e.a || {31'd0, redirQ} !== e.b) begin
               nMismatched++;
               $display("FAIL %s: npc_q=%h redir=%b, expected npc_q=%h redir=%0d", e.name, npcQ, redirQ, e.a, e.b);
            end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_branch();
      test_jump();
      test_jreg();
      test_registered();
      test_reset_midstream();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
